// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// master = control side driving operands; slave = the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sb_q, diff_q;
    logic [CntW-1:0]   cnt_q;
    logic              bor_q;
    logic              accept, last_bit, d_bit, bor_next;

    always_comb begin
        accept   = (state_q == StIdle) && bus.start;
        last_bit = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
        // Full-subtractor cell on the current LSBs.
        d_bit    = sa_q[0] ^ sb_q[0] ^ bor_q;
        bor_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bor_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            bor_q  <= 1'b0;
        end else if (accept) begin
            // diff is left alone here so the previous result stays visible until the first RUN edge.
            sa_q  <= bus.a;
            sb_q  <= bus.b;
            cnt_q <= '0;
            bor_q <= 1'b0;
        end else if (state_q == StRun) begin
            sa_q   <= sa_q >> 1;
            sb_q   <= sb_q >> 1;
            diff_q <= {d_bit, diff_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CntW'(1);
            bor_q  <= bor_next;
        end
    end

`ifdef SERSUB_OVF_EN
    logic ovf_q;

    // On the last bit sa_q[0]/sb_q[0] hold the captured operand MSBs and d_bit is the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= (sa_q[0] ^ sb_q[0]) & (d_bit ^ sa_q[0]);
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bor_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random operands
// checked against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular/unsigned/signed arithmetic.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        return W'((int'(av) - int'(bv)) & ((1 << W) - 1));
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (int'(av) < int'(bv));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int r;
        r = int'($signed(av)) - int'($signed(bv));
`ifdef SERSUB_OVF_EN
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
`else
        return (r != r);
`endif
    endfunction

    // Waits (bounded) for done at a negedge; timed_out set if no done seen.
    task automatic wait_done(output int t, output bit timed_out);
        timed_out = 1'b1;
        t = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                t = cyc;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [W-1:0] prev_diff;
        int           n;
        bit           busy_ok;
        @(negedge clk);
        prev_diff = bus.diff;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        check({tag, "_diff_held"}, 32'(bus.diff), 32'(prev_diff));
        check({tag, "_ovf_clr"}, 32'(bus.overflow), 32'd0);
        n = 0;
        busy_ok = 1'b1;
        while (n < 4 * W) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ref_diff(av, bv)));
        check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(ref_borrow(av, bv)));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(ref_ovf(av, bv)));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
        check({tag, "_diff_hold"}, 32'(bus.diff), 32'(ref_diff(av, bv)));
    endtask

    initial begin
        int          t1, t2, dc;
        bit          to1, to2;
        logic [W-1:0] ra, rb;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({bus.busy, bus.done, bus.borrow_out, bus.overflow}), 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd100, 8'd37, "t1");
        do_op(8'd5, 8'd10, "t2");

        // Held start: back-to-back ops separated by one IDLE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        @(posedge clk);
        #1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        wait_done(t1, to1);
        check("t3_first_timeout", 32'(to1), 32'd0);
        check("t3_first_diff", 32'({bus.diff, bus.borrow_out}), 32'd0);
        @(negedge clk);
        wait_done(t2, to2);
        bus.start = 1'b0;
        check("t3_second_timeout", 32'(to2), 32'd0);
        check("t3_second_diff", 32'({bus.diff, bus.borrow_out}), 32'd0);
        check("t3_gap", 32'(t2 - t1), 32'(W + 2));
        repeat (3) @(negedge clk);

        // Start re-pulsed during RUN is ignored.
        dc = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd20;
        bus.b     = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(t1, to1);
        check("t4_timeout", 32'(to1), 32'd0);
        check("t4_diff", 32'(bus.diff), 32'd17);
        repeat (3 * W) @(negedge clk);
        check("t4_one_done", 32'(done_cnt - dc), 32'd1);

        // Reset at RUN cnt=4 aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'h0F;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'({bus.busy, bus.done, bus.borrow_out, bus.overflow}), 32'd0);
        check("t5_rst_diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (2 * W) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - dc), 32'd0);
        do_op(8'd9, 8'd4, "t5_next");

        do_op(8'h80, 8'h01, "t6");
        do_op(8'h7F, 8'hFF, "t6b");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
